// File: rtl/nbj_fetch_redirect_queue.sv
// Buffers nbj-stage {next PC, cut position} results and drains them as fetch requests;
// a correction flush discards queued work and issues a redirect fetch to the corrected PC.
module nbj_fetch_redirect_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_drive,
    input  logic [31:0]      i_nextPc_32,
    input  logic [7:0]       i_cutPosition_8,
    output logic             o_free,
    input  logic             i_flush,
    input  logic [31:0]      i_flushPc_32,
    output logic             o_fetchReq,
    output logic [31:0]      o_fetchPc_32,
    output logic [7:0]       o_cutPosition_8,
    output logic             o_redirect,
    input  logic             i_fetchAck,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned ENTRY_W = 40;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_FLUSH_REQ = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        pc_q, pc_d;
    logic [7:0]         cut_q, cut_d;
    logic               req_q, req_d;
    logic               redir_q, redir_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic               free_c;
    logic               push_c;
    logic               pop_c;

    // Ready comes from the registered count only, so a same-cycle pop never frees a full queue
    assign free_c = (count_q != CNT_W'(DEPTH));
    assign push_c = i_drive && free_c && !i_flush;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        pc_d    = pc_q;
        cut_d   = cut_q;
        req_d   = req_q;
        redir_d = redir_q;
        pop_c   = 1'b0;

        if (i_flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
            pc_d    = i_flushPc_32;
            cut_d   = 8'h00;
            state_d = ST_FLUSH_REQ;
            req_d   = 1'b1;
            redir_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (count_q != '0) pop_c = 1'b1;
                end
                ST_REQ, ST_FLUSH_REQ: begin
                    if (i_fetchAck) begin
                        if (count_q != '0) begin
                            pop_c = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            req_d   = 1'b0;
                            redir_d = 1'b0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Head moves into the output register; back-to-back when acked with work queued
            if (pop_c) begin
                {pc_d, cut_d} = mem_q[rd_q];
                rd_d          = rd_q + PTR_W'(1);
                state_d       = ST_REQ;
                req_d         = 1'b1;
                redir_d       = 1'b0;
            end
            if (push_c) wr_d = wr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            pc_q    <= '0;
            cut_q   <= '0;
            req_q   <= 1'b0;
            redir_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            cut_q   <= cut_d;
            req_q   <= req_d;
            redir_q <= redir_d;
        end
    end

    // Storage is not reset; occupancy tracking guards every read
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_q] <= {i_nextPc_32, i_cutPosition_8};
    end

    assign o_free          = free_c;
    assign o_fetchReq      = req_q;
    assign o_fetchPc_32    = pc_q;
    assign o_cutPosition_8 = cut_q;
    assign o_redirect      = redir_q;
    assign o_count         = count_q;

endmodule

// File: tb/tb_nbj_fetch_redirect_queue.sv
// Randomized and directed bench for nbj_fetch_redirect_queue against a queue-based reference model.
module tb_nbj_fetch_redirect_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             i_drive = 1'b0;
    logic [31:0]      i_nextPc_32 = '0;
    logic [7:0]       i_cutPosition_8 = '0;
    logic             o_free;
    logic             i_flush = 1'b0;
    logic [31:0]      i_flushPc_32 = '0;
    logic             o_fetchReq;
    logic [31:0]      o_fetchPc_32;
    logic [7:0]       o_cutPosition_8;
    logic             o_redirect;
    logic             i_fetchAck = 1'b0;
    logic [CNT_W-1:0] o_count;

    int total = 0;
    int bad   = 0;

    // Reference model: pending entries plus the one request being offered
    logic [39:0] mq[$];
    logic        m_valid;
    logic [31:0] m_pc;
    logic [7:0]  m_cut;
    logic        m_redir;

    nbj_fetch_redirect_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .i_drive(i_drive), .i_nextPc_32(i_nextPc_32),
        .i_cutPosition_8(i_cutPosition_8), .o_free(o_free), .i_flush(i_flush),
        .i_flushPc_32(i_flushPc_32), .o_fetchReq(o_fetchReq), .o_fetchPc_32(o_fetchPc_32),
        .o_cutPosition_8(o_cutPosition_8), .o_redirect(o_redirect),
        .i_fetchAck(i_fetchAck), .o_count(o_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_valid = 1'b0;
        m_pc    = '0;
        m_cut   = '0;
        m_redir = 1'b0;
    endtask

    // One rising edge worth of behaviour, from the sampled inputs
    task automatic model_step();
        logic can_push;
        can_push = (mq.size() != DEPTH);
        if (i_flush) begin
            mq.delete();
            m_valid = 1'b1;
            m_pc    = i_flushPc_32;
            m_cut   = 8'h00;
            m_redir = 1'b1;
        end else begin
            if (m_valid && i_fetchAck) begin
                m_valid = 1'b0;
                m_redir = 1'b0;
            end
            if (!m_valid && mq.size() > 0) begin
                {m_pc, m_cut} = mq.pop_front();
                m_valid = 1'b1;
                m_redir = 1'b0;
            end
            if (i_drive && can_push) mq.push_back({i_nextPc_32, i_cutPosition_8});
        end
    endtask

    task automatic compare_all();
        check("fetchReq", 64'(o_fetchReq), 64'(m_valid));
        check("redirect", 64'(o_redirect), 64'(m_redir));
        check("count", 64'(o_count), 64'(mq.size()));
        check("free", 64'(o_free), 64'(mq.size() != DEPTH));
        if (m_valid) begin
            check("fetchPc", 64'(o_fetchPc_32), 64'(m_pc));
            check("cut", 64'(o_cutPosition_8), 64'(m_cut));
        end
    endtask

    // Called at a falling edge: apply inputs, take one rising edge, check at the next falling edge
    task automatic cycle(input logic drv, input logic [31:0] pc, input logic [7:0] cut,
                         input logic fl, input logic [31:0] fpc, input logic ack);
        i_drive         = drv;
        i_nextPc_32     = pc;
        i_cutPosition_8 = cut;
        i_flush         = fl;
        i_flushPc_32    = fpc;
        i_fetchAck      = ack;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_req", 64'(o_fetchReq), 64'd0);
        check("rst_pc", 64'(o_fetchPc_32), 64'd0);
        check("rst_cut", 64'(o_cutPosition_8), 64'd0);
        check("rst_free", 64'(o_free), 64'd1);
        check("rst_count", 64'(o_count), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single push: request visible two edges after the push is applied
        cycle(1'b1, 32'h0000_1000, 8'h03, 1'b0, '0, 1'b0);
        check("s1_noreq_yet", 64'(o_fetchReq), 64'd0);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
        check("s1_req", 64'(o_fetchReq), 64'd1);
        check("s1_pc", 64'(o_fetchPc_32), 64'h1000);
        check("s1_cut", 64'(o_cutPosition_8), 64'h03);
        check("s1_redir", 64'(o_redirect), 64'd0);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b1);
        check("s1_idle", 64'(o_fetchReq), 64'd0);
        check("s1_count", 64'(o_count), 64'd0);

        // Fill with ack low, sixth push held off, then drain with no bubble
        for (int i = 1; i <= 6; i++)
            cycle(1'b1, 32'(i * 32'h100), 8'(i), 1'b0, '0, 1'b0);
        check("fill_count", 64'(o_count), 64'd4);
        check("fill_free", 64'(o_free), 64'd0);
        check("fill_head", 64'(o_fetchPc_32), 64'h100);
        for (int i = 2; i <= 5; i++) begin
            cycle(1'b0, '0, '0, 1'b0, '0, 1'b1);
            check("drain_pc", 64'(o_fetchPc_32), 64'(i * 32'h100));
            check("drain_req", 64'(o_fetchReq), 64'd1);
        end
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b1);
        check("drain_idle", 64'(o_fetchReq), 64'd0);

        // Flush mid-stream with three queued and a request pending
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, 32'(32'h2000 + i), 8'(i), 1'b0, '0, 1'b0);
        check("pre_flush_count", 64'(o_count), 64'd3);
        cycle(1'b0, '0, '0, 1'b1, 32'hDEAD_BEE0, 1'b0);
        check("fl_count", 64'(o_count), 64'd0);
        check("fl_pc", 64'(o_fetchPc_32), 64'hDEAD_BEE0);
        check("fl_cut", 64'(o_cutPosition_8), 64'd0);
        check("fl_redir", 64'(o_redirect), 64'd1);

        // Flush together with push and ack
        cycle(1'b1, 32'h300, 8'h07, 1'b1, 32'h4000, 1'b1);
        check("fpa_pc", 64'(o_fetchPc_32), 64'h4000);
        check("fpa_count", 64'(o_count), 64'd0);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b1);
        check("fpa_idle", 64'(o_fetchReq), 64'd0);

        // Random traffic exercising wraparound, full/empty and occasional flushes
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom_range(0, 2) != 0), $urandom, 8'($urandom),
                  1'($urandom_range(0, 40) == 0), $urandom, 1'($urandom_range(0, 1)));

        // Async reset between edges while a request is outstanding
        cycle(1'b1, 32'h5000, 8'h11, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
        check("ar_pre_req", 64'(o_fetchReq), 64'd1);
        #2 rst = 1'b0;
        #1 check("ar_req_drop", 64'(o_fetchReq), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 32'h0000_1000, 8'h03, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b0);
        check("ar_post_pc", 64'(o_fetchPc_32), 64'h1000);
        check("ar_post_req", 64'(o_fetchReq), 64'd1);
        cycle(1'b0, '0, '0, 1'b0, '0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
